// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel runs a synchroniser, a counter-based debouncer, press/release
// strobes and a toggle latch. All outputs are registered on MCLK.
// Define BUTTON_CONDITIONER_LONG_PRESS_EN to build the per-channel hold
// counter and LONG strobe. Without it, LONG is held at 0.

module button_conditioner_chan #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_WIDTH     = 18,
    parameter int ACTIVE_LOW    = 1,
    parameter int LONG_CYCLES   = 25000000,
    parameter int LONG_WIDTH    = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_toggle,
    output logic o_long
);
    // The raw level seen while the button is not pressed.
    localparam logic                 IDLE    = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_toggle;
    logic                   w_sample;

    // Normalised sample: 1 means pressed, regardless of board polarity.
    assign w_sample = r_sync[SYNC_STAGES-1] ^ IDLE;

    // Synchroniser chain. Reset loads the idle level so that leaving reset
    // never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Debounce counter, accepted level, edge strobes and toggle latch.
    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt     <= '0;
                r_level   <= w_sample;
                r_press   <= w_sample;
                r_release <= ~w_sample;
                if (w_sample) begin
                    r_toggle <= ~r_toggle;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_toggle  = r_toggle;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] HOLD_MAX = LONG_WIDTH'(LONG_CYCLES);
    localparam logic [LONG_WIDTH-1:0] HOLD_PRE = LONG_WIDTH'(LONG_CYCLES - 1);

    logic [LONG_WIDTH-1:0] r_hold;
    logic                  r_long;

    // Hold counter saturates at LONG_CYCLES, so the strobe fires only on the
    // single edge where it reaches the limit; release clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= r_level && (r_hold == HOLD_PRE);
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

module button_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_WIDTH     = 18,
    parameter int ACTIVE_LOW    = 1,
    parameter int LONG_CYCLES   = 25000000,
    parameter int LONG_WIDTH    = 25
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] BT_IN,
    output logic [CHANNELS-1:0] LEVEL,
    output logic [CHANNELS-1:0] PRESS,
    output logic [CHANNELS-1:0] RELEASE,
    output logic [CHANNELS-1:0] TOGGLE,
    output logic [CHANNELS-1:0] LONG
);

    // Channels are fully independent; no arbitration between them.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_conditioner_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_WIDTH    (CNT_WIDTH),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .LONG_CYCLES  (LONG_CYCLES),
            .LONG_WIDTH   (LONG_WIDTH)
        ) u_chan (
            .i_clk    (MCLK),
            .i_rst    (RST),
            .i_raw    (BT_IN[g]),
            .o_level  (LEVEL[g]),
            .o_press  (PRESS[g]),
            .o_release(RELEASE[g]),
            .o_toggle (TOGGLE[g]),
            .o_long   (LONG[g])
        );
    end

endmodule
